adc_spi_capture: RTL and testbench
==================================

Name: adc_spi_capture

Overview:
- Consumes the controller's active-low `adc_trg` pulse train and the current `rot_count`.
- On each trigger, runs one SPI read of a 12-bit serial ADC (16-bit frame: 4 leading zeros, then data MSB first).
- Averages 2^AVG_LOG2 conversions taken at the same rotation angle.
- Presents each averaged sample, tagged with its angle, on a valid/ready port to the downstream logger/UART stage.

Parameters:
- SCLK_DIV, 4: clk50 cycles per SCLK half-period (4 gives 6.25 MHz SCLK).
- FRAME_BITS, 16: SCLK cycles per conversion frame.
- ADC_BITS, 12: data bits; the LSBs of the frame.
- AVG_LOG2, 2: log2 of samples averaged per result (0 means no averaging).
- ANGLE_W, 10: width of the rotation count tag.

Ports:
- clk50 in 1: 50 MHz system clock.
- rst_n in 1: asynchronous, active-low reset.
- adc_trg in 1: active-low conversion request from controller; asynchronous to this block's FSM timing.
- rot_count in ANGLE_W: current rotation step count.
- adc_sdata in 1: ADC serial data out.
- adc_cs_n out 1: ADC chip select, active low.
- adc_sclk out 1: ADC serial clock, idles high.
- out_data out ADC_BITS: averaged sample.
- out_angle out ANGLE_W: rot_count tag of out_data.
- out_valid out 1: result available.
- out_ready in 1: downstream accepts the result.
- overrun out 1: sticky error flag.
- overrun_clr in 1: one-cycle clear of overrun.
- busy out 1: conversion in progress.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=1, out_data=0, out_angle=0, out_valid=0, overrun=0, busy=0. The accumulator and sample count also clear on reset. Reset asserted mid-frame forces adc_cs_n=1 and adc_sclk=1 immediately (asynchronous).
- Trigger path:
  - adc_trg passes through a 2-FF synchronizer.
  - A falling edge of the synchronized signal is one trigger event, 3 cycles after the pin edge.
  - A trigger in IDLE starts a frame.
  - A trigger in any other state is dropped and sets overrun.
- FSM states and transitions:
  - IDLE → SETUP on trigger. SETUP drives cs_n=0 and lasts SCLK_DIV cycles; rot_count is latched as the sample angle at SETUP entry.
  - SHIFT runs FRAME_BITS SCLK periods. Each period is SCLK_DIV cycles low, then SCLK_DIV cycles high. adc_sdata is sampled on the clk50 edge that drives sclk low→high. Bits shift in MSB first.
  - QUIET drives cs_n=1 for SCLK_DIV cycles, then moves to ACCUM.
  - ACCUM takes 1 cycle, then returns to IDLE.
  - busy=1 in every state except IDLE.
  - Frame length with defaults: 4 + 128 + 4 + 1 = 137 cycles from trigger detection to IDLE.
- Frame decode: sample = low ADC_BITS of the shift register. The leading FRAME_BITS-ADC_BITS bits are ignored, not checked.
- Accumulation (in ACCUM):
  - Accumulator width is ADC_BITS+AVG_LOG2 and cannot overflow.
  - If cnt==0, or the sample angle differs from the group angle: acc=sample, cnt=1, group angle = sample angle. A partial group is discarded silently, with no overrun.
  - Otherwise: acc+=sample, cnt+=1.
  - When cnt reaches 2^AVG_LOG2: result = acc >> AVG_LOG2 (truncating), then cnt=0.
- Output handshake:
  - The result loads out_data/out_angle and sets out_valid on the cycle after ACCUM.
  - out_valid, out_data and out_angle hold stable until a cycle with out_valid && out_ready; that cycle clears out_valid.
  - If a result completes while out_valid=1 and out_ready=0, the new result is dropped, overrun is set and the old result is kept.
  - If out_ready=1 on the same cycle a new result loads, the old result is consumed and the new one loads (valid stays 1).
- Overrun:
  - Cleared only by overrun_clr or reset.
  - A set event and overrun_clr on the same cycle leave overrun=1 (set wins).
- Capture never stalls on backpressure; only results are dropped.

Decomposition:
- Shared package cmb_pkg holds:
  - constants CMB_ANGLE_W=10, CMB_ADC_BITS=12, CMB_FRAME_BITS=16;
  - the FSM state encoding for this block (typedef enum IDLE/SETUP/SHIFT/QUIET/ACCUM).
- One sub-module, adc_spi_rx, owns SCLK generation, cs_n and the shift register. Handshake: start pulse in; done pulse plus sample out.
- Triggering, averaging and the output register stay in adc_spi_capture.

Test Plan:
- AVG_LOG2=2, rot_count=37, ADC model returns 100,102,104,106 on four triggers 200 cycles apart → out_valid with out_data=103, out_angle=37. Exactly 4 frames of 16 SCLK rising edges each; cs_n low throughout each frame.
- ADC frame 0xF0AB (nonzero leading bits), AVG_LOG2=0 → out_data=0x0AB.
- Trigger issued 50 cycles after a prior trigger → second trigger dropped, overrun=1, busy stays 1. overrun_clr pulse → overrun=0.
- Two samples at rot_count=5, then rot_count=6 for the next four samples of 10 each → single result out_data=10, out_angle=6; no overrun.
- out_ready held 0 across two complete groups → first result held unchanged, second dropped, overrun=1. Then out_ready=1 for one cycle → out_valid=0.
- rst_n pulled low at SCLK edge 8 of a frame → cs_n=1 and sclk=1 immediately. After release, the next trigger yields a clean frame and cnt restarts from 0.

Source files
------------

// File: rtl/cmb_pkg.sv
// cmb_pkg: shared widths and the capture FSM state encoding
package cmb_pkg;
  localparam int CMB_ANGLE_W    = 10;
  localparam int CMB_ADC_BITS   = 12;
  localparam int CMB_FRAME_BITS = 16;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, ACCUM} state_t;
endpackage

// File: rtl/adc_spi_capture_if.sv
// adc_spi_capture_if: averaged-sample valid/ready result port
interface adc_spi_capture_if import cmb_pkg::*; #(
  parameter int ADC_BITS = CMB_ADC_BITS,
  parameter int ANGLE_W  = CMB_ANGLE_W
) ();
  logic [ADC_BITS-1:0] out_data;
  logic [ANGLE_W-1:0]  out_angle;
  logic                out_valid;
  logic                out_ready;
  modport master (output out_data, out_angle, out_valid, input out_ready);
  modport slave  (input out_data, out_angle, out_valid, output out_ready);
endinterface

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: one SPI frame read (cs_n, sclk, shift register), done pulse in ACCUM
module adc_spi_rx import cmb_pkg::*; #(
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = CMB_FRAME_BITS,
  parameter int ADC_BITS   = CMB_ADC_BITS
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sdata,
  output logic                cs_n,
  output logic                sclk,
  output logic                done,
  output logic                busy,
  output logic [ADC_BITS-1:0] sample
);
  localparam int HW = $clog2(2 * SCLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  state_t              st;
  logic [HW-1:0]       hc;
  logic [BW-1:0]       bc;
  logic [ADC_BITS-1:0] sr;
  logic                half, full, wait_end;
  always_comb begin
    half     = hc == HW'(SCLK_DIV - 1);
    full     = hc == HW'(2 * SCLK_DIV - 1);
    wait_end = half;
    done     = st == ACCUM;
    busy     = st != IDLE;
    sample   = sr;
  end
  // only the last ADC_BITS shifted bits survive, so the leading frame bits fall off the top
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      st   <= IDLE;
      cs_n <= 1'b1;
      sclk <= 1'b1;
      hc   <= '0;
      bc   <= '0;
      sr   <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          st   <= SETUP;
          cs_n <= 1'b0;
          hc   <= '0;
        end
        SETUP: begin
          hc <= hc + HW'(1);
          if (wait_end) begin
            st   <= SHIFT;
            sclk <= 1'b0;
            hc   <= '0;
            bc   <= '0;
          end
        end
        SHIFT: begin
          hc <= hc + HW'(1);
          if (half) begin
            sclk <= 1'b1;
            sr   <= {sr[ADC_BITS-2:0], sdata};
          end
          if (full) begin
            hc <= '0;
            bc <= bc + BW'(1);
            if (bc == BW'(FRAME_BITS - 1)) begin
              st   <= QUIET;
              cs_n <= 1'b1;
            end else
              sclk <= 1'b0;
          end
        end
        QUIET: begin
          hc <= hc + HW'(1);
          if (wait_end) begin
            st <= ACCUM;
            hc <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: trigger sync, same-angle averaging and result register for a serial ADC
module adc_spi_capture import cmb_pkg::*; #(
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = CMB_FRAME_BITS,
  parameter int ADC_BITS   = CMB_ADC_BITS,
  parameter int AVG_LOG2   = 2,
  parameter int ANGLE_W    = CMB_ANGLE_W
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic               adc_trg,
  input  logic [ANGLE_W-1:0] rot_count,
  input  logic               adc_sdata,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               busy,
  adc_spi_capture_if.master  bus
);
  localparam int AW = ADC_BITS + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  logic [2:0]          ts;
  logic                trig, start, done, fresh, full, lost;
  logic [ADC_BITS-1:0] sample;
  logic [ANGLE_W-1:0]  ang, gang;
  logic [AW-1:0]       acc, nacc;
  logic [CW-1:0]       cnt, ncnt;
  adc_spi_rx #(.SCLK_DIV(SCLK_DIV), .FRAME_BITS(FRAME_BITS), .ADC_BITS(ADC_BITS)) rx (
    .clk50(clk50), .rst_n(rst_n), .start(start), .sdata(adc_sdata),
    .cs_n(adc_cs_n), .sclk(adc_sclk), .done(done), .busy(busy), .sample(sample)
  );
  // ts[1:0] synchronize the pin, ts[2] is the previous synchronized level
  always_comb begin
    trig  = ts[2] & ~ts[1];
    start = trig & ~busy;
    fresh = cnt == '0 || ang != gang;
    nacc  = fresh ? AW'(sample) : acc + AW'(sample);
    ncnt  = fresh ? CW'(1) : cnt + CW'(1);
    full  = done && ncnt == CW'(1 << AVG_LOG2);
    lost  = full && bus.out_valid && !bus.out_ready;
  end
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      ts            <= '1;
      ang           <= '0;
      gang          <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_angle <= '0;
      overrun       <= 1'b0;
    end else begin
      ts <= {ts[1:0], adc_trg};
      if (start) ang <= rot_count;
      if (done) begin
        acc  <= nacc;
        cnt  <= full ? '0 : ncnt;
        gang <= ang;
      end
      if (full && !lost) begin
        bus.out_data  <= ADC_BITS'(nacc >> AVG_LOG2);
        bus.out_angle <= ang;
      end
      bus.out_valid <= (full && !lost) || (bus.out_valid && !bus.out_ready);
      overrun       <= (trig && busy) || lost || (overrun && !overrun_clr);
    end
endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: table vectors, corner sequences and a randomized grouping model
module tb_adc_spi_capture;
  import cmb_pkg::*;
  logic       clk50 = 0, rst_n = 0, adc_trg = 1, overrun_clr = 0;
  logic       adc_sdata, adc_cs_n, adc_sclk, overrun, busy;
  logic [9:0] rot_count = 0;
  adc_spi_capture_if #(.ADC_BITS(12), .ANGLE_W(10)) bus();
  adc_spi_capture #(.SCLK_DIV(4), .FRAME_BITS(16), .ADC_BITS(12), .AVG_LOG2(2), .ANGLE_W(10)) dut (
    .clk50(clk50), .rst_n(rst_n), .adc_trg(adc_trg), .rot_count(rot_count), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .overrun(overrun), .overrun_clr(overrun_clr),
    .busy(busy), .bus(bus)
  );
  always #10 clk50 = ~clk50;

  int pass_n = 0, tot = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ADC model: frame loaded at cs_n fall, bit index advances after each sclk rise
  logic [15:0] fq[$];
  logic [15:0] frame = 0;
  int          rises = 0, nfr = 0, stray = 0;
  bit          frm_chk = 0, mon_en = 0;
  assign adc_sdata = (rises < 16) ? frame[15-rises] : 1'b0;
  always @(negedge adc_cs_n) begin
    frame = fq.size() != 0 ? fq.pop_front() : 16'h0;
    rises = 0;
    nfr++;
  end
  always @(posedge adc_sclk)
    if (rst_n && !adc_cs_n) rises++;
    else if (rst_n) stray++;
  always @(negedge adc_sclk)
    if (rst_n && adc_cs_n) stray++;
  always @(posedge adc_cs_n)
    if (frm_chk) chk("sclk_rises_per_frame", rises, 16);

  typedef struct packed {logic [11:0] d; logic [9:0] a;} res_t;
  res_t        expq[$];
  res_t        e;
  logic [11:0] grp[$];
  logic [9:0]  gang;
  always @(negedge clk50)
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = expq.pop_front();
        chk("rand_data", bus.out_data, e.d);
        chk("rand_angle", bus.out_angle, e.a);
      end
    end

  task automatic model_push(input logic [15:0] f, input logic [9:0] a);
    int s;
    if (grp.size() == 0 || a != gang) begin
      grp.delete();
      gang = a;
    end
    grp.push_back(f[11:0]);
    if (grp.size() == 4) begin
      s = 0;
      foreach (grp[j]) s += grp[j];
      expq.push_back('{d: 12'(s / 4), a: a});
      grp.delete();
    end
  endtask

  task automatic trig_pulse();
    @(negedge clk50) adc_trg = 0;
    repeat (3) @(negedge clk50);
    adc_trg = 1;
  endtask

  task automatic conv(input logic [15:0] f, input logic [9:0] a);
    fq.push_back(f);
    rot_count = a;
    trig_pulse();
    repeat (150) @(negedge clk50);
  endtask

  task automatic consume();
    @(negedge clk50) bus.out_ready = 1;
    @(negedge clk50) bus.out_ready = 0;
    chk("consumed_valid", bus.out_valid, 0);
  endtask

  typedef struct packed {logic [3:0][15:0] f; logic [9:0] ang; logic [11:0] exp;} vec_t;
  vec_t tv[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, c;
    logic [9:0] ra;
    logic [15:0] rf;
    bus.out_ready = 0;
    tv[0] = '{f: {16'd106, 16'd104, 16'd102, 16'd100}, ang: 10'd37, exp: 12'd103};
    tv[1] = '{f: {16'hF0AB, 16'hF0AB, 16'hF0AB, 16'hF0AB}, ang: 10'd38, exp: 12'h0AB};
    tv[2] = '{f: {16'd3, 16'd0, 16'd0, 16'd0}, ang: 10'd39, exp: 12'd0};
    tv[3] = '{f: {16'hAFFF, 16'hAFFF, 16'hAFFF, 16'hAFFF}, ang: 10'd40, exp: 12'hFFF};
    tv[4] = '{f: {16'h0FFE, 16'h0FFF, 16'h0FFF, 16'h0FFF}, ang: 10'd41, exp: 12'hFFE};
    tv[5] = '{f: {16'd4, 16'd3, 16'd2, 16'd1}, ang: 10'd0, exp: 12'd2};
    repeat (3) @(negedge clk50);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_data", bus.out_data, 0);
    chk("rst_angle", bus.out_angle, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    repeat (3) @(negedge clk50);
    frm_chk = 1;
    for (int i = 0; i < 6; i++) begin
      n0 = nfr;
      for (int k = 0; k < 4; k++) begin
        conv(tv[i].f[k], tv[i].ang);
        if (k == 2) chk("no_early_result", bus.out_valid, 0);
      end
      chk("frames_per_group", nfr - n0, 4);
      chk("vec_valid", bus.out_valid, 1);
      chk("vec_data", bus.out_data, tv[i].exp);
      chk("vec_angle", bus.out_angle, tv[i].ang);
      chk("vec_overrun", overrun, 0);
      consume();
    end
    // second trigger lands mid-frame
    fq.push_back(16'd50);
    rot_count = 99;
    trig_pulse();
    repeat (47) @(negedge clk50);
    trig_pulse();
    repeat (5) @(negedge clk50);
    chk("ovr_busy", busy, 1);
    chk("ovr_set", overrun, 1);
    repeat (120) @(negedge clk50);
    chk("ovr_idle", busy, 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_frames", fq.size(), 0);
    @(negedge clk50) overrun_clr = 1;
    @(negedge clk50) overrun_clr = 0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_no_result", bus.out_valid, 0);
    conv(16'd20, 10'd5);
    conv(16'd20, 10'd5);
    for (int k = 0; k < 4; k++) begin
      conv(16'd10, 10'd6);
      if (k == 2) chk("angchg_early", bus.out_valid, 0);
    end
    chk("angchg_valid", bus.out_valid, 1);
    chk("angchg_data", bus.out_data, 10);
    chk("angchg_angle", bus.out_angle, 6);
    chk("angchg_overrun", overrun, 0);
    consume();
    // backpressure across two groups
    for (int k = 0; k < 4; k++) conv(16'd20, 10'd8);
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_overrun", overrun, 0);
    for (int k = 0; k < 4; k++) conv(16'd40, 10'd9);
    chk("bp_valid_held", bus.out_valid, 1);
    chk("bp_data_held", bus.out_data, 20);
    chk("bp_angle_held", bus.out_angle, 8);
    chk("bp_overrun", overrun, 1);
    consume();
    @(negedge clk50) overrun_clr = 1;
    @(negedge clk50) overrun_clr = 0;
    // reset in the middle of a frame with a partial group pending
    conv(16'd400, 10'd7);
    conv(16'd400, 10'd7);
    fq.push_back(16'd999);
    trig_pulse();
    for (c = 0; c < 300 && rises < 8; c++) @(negedge clk50);
    chk("reach_edge8", rises, 8);
    repeat (5) @(negedge clk50);
    chk("pre_rst_cs_n", adc_cs_n, 0);
    chk("pre_rst_sclk", adc_sclk, 0);
    frm_chk = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_cs_n", adc_cs_n, 1);
    chk("mid_rst_sclk", adc_sclk, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk50);
    rst_n = 1;
    repeat (3) @(negedge clk50);
    frm_chk = 1;
    for (int k = 0; k < 4; k++) begin
      conv(16'd8, 10'd7);
      if (k == 1) chk("cnt_restart", bus.out_valid, 0);
    end
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_data", bus.out_data, 8);
    chk("post_rst_angle", bus.out_angle, 7);
    consume();
    // randomized grouping against the reference model
    bus.out_ready = 1;
    mon_en = 1;
    ra = 10'd2;
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 10'($urandom_range(0, 3));
      rf = 16'($urandom);
      model_push(rf, ra);
      conv(rf, ra);
    end
    repeat (20) @(negedge clk50);
    chk("rand_all_seen", expq.size(), 0);
    chk("rand_overrun", overrun, 0);
    chk("no_stray_sclk", stray, 0);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
